csa_64_adder: RTL and testbench
===============================

Name: csa_64_adder

Overview:
- 64-bit carry-select adder computing a + b + c_in, with 64-bit sum and carry-out.
- Datapath is purely combinational: ripple-carry blocks, each duplicated for carry-in 0 and carry-in 1, with block carry selecting the result.
- Results are registered once on clk, giving a fixed 1-cycle latency.
- Used as the 64-bit integer add primitive; checked against a behavioural a+b+c_in golden model.

Parameters:
- WIDTH, 64, operand and sum width; must be an integer multiple of BLOCK.
- BLOCK, 4, bits per carry-select block; the lowest block is a plain ripple adder fed by c_in.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum bits [WIDTH-1:0] of a+b+c_in.
- c_out  output  1  registered carry-out (bit WIDTH) of a+b+c_in.

Behaviour:
- Core arithmetic: {c_out_next, s_next} = a + b + c_in, computed over a (WIDTH+1)-bit result. Unsigned, no overflow flag, no saturation.
- Block structure:
  - Block 0 (bits BLOCK-1:0) is a BLOCK-bit ripple adder using c_in.
  - Each higher block k has two BLOCK-bit ripple adders, one with carry-in 0 and one with carry-in 1.
  - Block k's sum and carry are muxed by block k-1's selected carry-out.
  - The final block's selected carry-out is c_out_next.
- Full adder per bit: s = a^b^ci; co = (a&b)|(ci&(a^b)).
- Register stage: on each rising clk edge, s <= s_next and c_out <= c_out_next.
- Latency: inputs sampled at edge N appear on s/c_out after edge N; there is no stall or handshake and a new operation is accepted every cycle.
- Reset: while reset=1 at a rising edge, s <= 0 and c_out <= 0. Reset has priority over the data update.
- First valid result follows the first edge with reset=0.
- Asserting reset mid-stream discards the in-flight result.
- Boundary cases:
  - All-ones + all-ones + 1 wraps, with c_out=1.
  - Carry must propagate through every block select chain, e.g. all-ones + 0 + 1 gives s=0, c_out=1.
  - No X propagation from the unused select path.
- Outputs change only on clk edges and never glitch combinationally.

Test Plan:
- Reset: assert reset for 2 cycles with a=b=all-ones, c_in=1 -> s=0x0, c_out=0 during reset.
- a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF, c_in=1 -> one cycle later s=0xFFFFFFFFFFFFFFFF, c_out=1.
- a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFE:
  - c_in=1 -> s=0xFFFFFFFFFFFFFFFE, c_out=1.
  - c_in=0 -> s=0xFFFFFFFFFFFFFFFD, c_out=1.
- a=0xFFFFFF0000000001, b=0xFFFFFF0000000760, c_in=1 -> s=0xFFFFFE0000000762, c_out=1. Full-chain propagation: a=0xFFFFFFFFFFFFFFFF, b=0, c_in=1 -> s=0, c_out=1.
- Small operands a=0x12, b=0x11:
  - c_in=1 -> s=0x24, c_out=0.
  - c_in=0 -> s=0x23, c_out=0.
- Mixed operands a=0x124552, b=0x47264:
  - c_in=1 -> s=0x16B7B7, c_out=0.
  - c_in=0 -> s=0x16B7B6, c_out=0.
- Random back-to-back: 10k random vectors, one per cycle, compared against the golden model delayed one cycle; no mismatch allowed.

Source files
------------

// File: rtl/csa_64_adder.sv
// csa_64_adder -- registered carry-select adder computing {c_out, s} = a + b + c_in.
//
// The operands are split into WIDTH/BLOCK blocks of BLOCK bits. Block 0 is a plain ripple
// adder fed by c_in. Every higher block holds two ripple adders, one assuming carry-in 0
// and one assuming carry-in 1. The selected carry of the block below picks which result
// is used. The full sum and carry are registered once, so the latency is one cycle. A new
// operation is accepted on every cycle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous active-high reset; clears s and c_out
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   c_in   in   1      carry into bit 0
//   s      out  WIDTH  registered sum bits [WIDTH-1:0]
//   c_out  out  1      registered carry-out (bit WIDTH)
module csa_64_adder #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   localparam int unsigned NumBlocks = WIDTH / BLOCK;

   // Stop elaboration if the block size does not tile the operand width exactly.
   if ((WIDTH % BLOCK) != 0 || BLOCK == 0) begin : g_bad_param
      $error("csa_64_adder: WIDTH must be a non-zero multiple of BLOCK");
   end

   // BLOCK-bit ripple adder. Result bit BLOCK is the carry-out.
   function automatic logic [BLOCK:0] ripple_add(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
      logic [BLOCK:0] res;
      logic           carry;
      logic           p;
      carry = ci;
      res   = '0;
      for (int unsigned i = 0; i < BLOCK; i++) begin
         p      = x[i] ^ y[i];
         res[i] = p ^ carry;
         carry  = (x[i] & y[i]) | (carry & p);
      end
      res[BLOCK] = carry;
      return res;
   endfunction

   // Per-block speculative results. For block 0, only the cin0 slot is used, and it is fed
   // with the real c_in.
   logic [BLOCK-1:0] sum_cin0 [NumBlocks];
   logic [BLOCK-1:0] sum_cin1 [NumBlocks];
   logic             co_cin0  [NumBlocks];
   logic             co_cin1  [NumBlocks];

   always_comb begin
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      for (int unsigned k = 0; k < NumBlocks; k++) begin
         if (k == 0) begin
            r0 = ripple_add(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], c_in);
            // Block 0 has no alternate path. Tie it to the real result so that
            // nothing undriven exists.
            r1 = r0;
         end else begin
            r0 = ripple_add(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b0);
            r1 = ripple_add(a[k*BLOCK +: BLOCK], b[k*BLOCK +: BLOCK], 1'b1);
         end
         sum_cin0[k] = r0[BLOCK-1:0];
         co_cin0[k]  = r0[BLOCK];
         sum_cin1[k] = r1[BLOCK-1:0];
         co_cin1[k]  = r1[BLOCK];
      end
   end

   // Select chain. Each block's selected carry-out picks the result of the block above.
   // Both speculative paths are always fully driven, so the unused one cannot leak X.
   logic [WIDTH-1:0] s_d;
   logic             c_out_d;

   always_comb begin
      logic sel_carry;
      s_d       = '0;
      sel_carry = 1'b0;
      for (int unsigned k = 0; k < NumBlocks; k++) begin
         if (k == 0) begin
            s_d[k*BLOCK +: BLOCK] = sum_cin0[k];
            sel_carry             = co_cin0[k];
         end else if (sel_carry) begin
            s_d[k*BLOCK +: BLOCK] = sum_cin1[k];
            sel_carry             = co_cin1[k];
         end else begin
            s_d[k*BLOCK +: BLOCK] = sum_cin0[k];
            sel_carry             = co_cin0[k];
         end
      end
      c_out_d = sel_carry;
   end

   // Output register. Reset has priority and discards any in-flight result.
   logic [WIDTH-1:0] s_q;
   logic             c_out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q     <= '0;
         c_out_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         c_out_q <= c_out_d;
      end
   end

   assign s     = s_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_csa_64_adder.sv
// Testbench for csa_64_adder. The stimulus pushes expected results into a queue. A
// separate monitor pops one entry after every clock edge and compares it with the DUT.
module tb_csa_64_adder;

   localparam int unsigned Width = 64;

   logic             clk;
   logic             reset;
   logic [Width-1:0] a;
   logic [Width-1:0] b;
   logic             c_in;
   logic [Width-1:0] s;
   logic             c_out;

   csa_64_adder #(
      .WIDTH(64),
      .BLOCK(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .a    (a),
      .b    (b),
      .c_in (c_in),
      .s    (s),
      .c_out(c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [Width:0] exp;
      string          name;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        checks = 0;
   int        errors = 0;

   // Golden model: plain unsigned arithmetic over Width+1 bits. Reset forces zero.
   task automatic issue(input logic r, input logic [Width-1:0] va, input logic [Width-1:0] vb,
                        input logic ci, input string name);
      sb_entry_t e;
      @(negedge clk);
      reset = r;
      a     = va;
      b     = vb;
      c_in  = ci;
      e.exp  = r ? '0 : ({1'b0, va} + {1'b0, vb} + {{Width{1'b0}}, ci});
      e.name = name;
      sb_q.push_back(e);
   endtask

   // Monitor: the entry pushed before this edge is the one the register captured.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() != 0) begin
         sb_entry_t e;
         e = sb_q.pop_front();
         checks++;
         if ({c_out, s} !== e.exp) begin
            errors++;
            $display("FAIL %s: got c_out=%0b s=%h, want c_out=%0b s=%h",
                     e.name, c_out, s, e.exp[Width], e.exp[Width-1:0]);
         end
      end
   end

   localparam logic [Width-1:0] Ones = {Width{1'b1}};

   initial begin
      reset = 1'b1;
      a     = '0;
      b     = '0;
      c_in  = 1'b0;

      // Reset with all-ones operands must still read zero.
      issue(1'b1, Ones, Ones, 1'b1, "reset0");
      issue(1'b1, Ones, Ones, 1'b1, "reset1");

      issue(1'b0, Ones, Ones, 1'b1, "ones_ones_c1");
      issue(1'b0, Ones, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "ones_fe_c1");
      issue(1'b0, Ones, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "ones_fe_c0");
      issue(1'b0, 64'hFFFF_FF00_0000_0001, 64'hFFFF_FF00_0000_0760, 1'b1, "mixed_hi");
      issue(1'b0, Ones, 64'h0, 1'b1, "full_chain");
      issue(1'b0, 64'h12, 64'h11, 1'b1, "small_c1");
      issue(1'b0, 64'h12, 64'h11, 1'b0, "small_c0");
      issue(1'b0, 64'h124552, 64'h47264, 1'b1, "mid_c1");
      issue(1'b0, 64'h124552, 64'h47264, 1'b0, "mid_c0");
      issue(1'b0, 64'h0, 64'h0, 1'b0, "zero");

      // A mid-stream reset discards the pending result.
      issue(1'b0, Ones, Ones, 1'b1, "pre_reset");
      issue(1'b1, Ones, Ones, 1'b1, "mid_reset");
      issue(1'b0, 64'h5, 64'h7, 1'b1, "post_reset");

      // Random back-to-back vectors. Every third one is a propagate-heavy pattern.
      for (int i = 0; i < 10000; i++) begin
         logic [Width-1:0] ra;
         logic [Width-1:0] rb;
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if (i % 3 == 0) rb = ~ra ^ ({$urandom(), $urandom()} & {$urandom(), $urandom()}
                                     & {$urandom(), $urandom()});
         issue(1'b0, ra, rb, 1'($urandom_range(0, 1)), "random");
      end

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
